// File: rtl/uni_reg_pkg.sv
// Shared constants for the uni_reg universal register: mode width and mode codes.
package uni_reg_pkg;

  localparam int UNI_REG_MODE_W = 3;

  localparam logic [UNI_REG_MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [UNI_REG_MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [UNI_REG_MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [UNI_REG_MODE_W-1:0] MODE_SHR  = 3'd3;
  localparam logic [UNI_REG_MODE_W-1:0] MODE_ROL  = 3'd4;
  localparam logic [UNI_REG_MODE_W-1:0] MODE_ROR  = 3'd5;
  localparam logic [UNI_REG_MODE_W-1:0] MODE_INC  = 3'd6;
  localparam logic [UNI_REG_MODE_W-1:0] MODE_DEC  = 3'd7;

endpackage

// File: rtl/mux8.sv
// Generic 8:1 single-bit multiplexer; input index equals the select code.
module mux8 (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = in[sel];

endmodule

// File: rtl/uni_reg_cell.sv
// One bit of uni_reg: mode-indexed 8:1 next-state select feeding a
// synchronous-reset flop that resets to its own bit of the register reset value.
module uni_reg_cell
  import uni_reg_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UNI_REG_MODE_W-1:0] mode,
  input  logic [7:0]                opts,
  output logic                      q
);

  logic nxt;

  mux8 u_mux (
    .in  (opts),
    .sel (mode),
    .y   (nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) q <= RST_BIT;
    else       q <= nxt;
  end

endmodule

// File: rtl/uni_reg.sv
// Parametrised universal register (hold/load/shift/rotate/inc/dec) with registered
// cout and combinational zero. Define UNI_REG_SAT_EN for saturating INC/DEC.
module uni_reg
  import uni_reg_pkg::*;
#(
  parameter int             WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UNI_REG_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]          d,
  input  logic                      sin_l,
  input  logic                      sin_r,
  output logic [WIDTH-1:0]          q,
  output logic                      cout,
  output logic                      zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v, inc_v, dec_v;
  logic             all_ones, all_zero;
  logic             cout_nxt;

  assign all_ones = &q;
  assign all_zero = ~|q;

  assign shl_v = {q[WIDTH-2:0], sin_l};
  assign shr_v = {sin_r, q[WIDTH-1:1]};
  assign rol_v = {q[WIDTH-2:0], q[WIDTH-1]};
  assign ror_v = {q[0], q[WIDTH-1:1]};

`ifdef UNI_REG_SAT_EN
  // Boundary counts stick at the rail instead of wrapping.
  assign inc_v = all_ones ? q : q + ONE;
  assign dec_v = all_zero ? q : q - ONE;
`else
  assign inc_v = q + ONE;
  assign dec_v = q - ONE;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    uni_reg_cell #(
      .RST_BIT (RESET_VAL[i])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .mode  (mode),
      .opts  ({dec_v[i], inc_v[i], ror_v[i], rol_v[i],
               shr_v[i], shl_v[i], d[i], q[i]}),
      .q     (q[i])
    );
  end

  // cout carries the bit leaving the register, or the wrap/saturation event on counts.
  always_comb begin
    cout_nxt = cout;
    case (mode)
      MODE_HOLD: cout_nxt = cout;
      MODE_LOAD: cout_nxt = 1'b0;
      MODE_SHL:  cout_nxt = q[WIDTH-1];
      MODE_SHR:  cout_nxt = q[0];
      MODE_ROL:  cout_nxt = q[WIDTH-1];
      MODE_ROR:  cout_nxt = q[0];
      MODE_INC:  cout_nxt = all_ones;
      MODE_DEC:  cout_nxt = all_zero;
      default:   cout_nxt = cout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cout <= 1'b0;
    else       cout <= cout_nxt;
  end

  assign zero = all_zero;

endmodule

// File: tb/tb_uni_reg.sv
// Self-checking bench for uni_reg (WIDTH=8, RESET_VAL=0); follows UNI_REG_SAT_EN
// when defined.
module tb_uni_reg;
  import uni_reg_pkg::*;

  localparam int W = 8;
`ifdef UNI_REG_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // clock / reset
  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin_l, sin_r;
  logic [W-1:0] q;
  logic         cout, zero;

  always #5 clk = ~clk;

  uni_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .d     (d),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .q     (q),
    .cout  (cout),
    .zero  (zero)
  );

  // scoreboard: {q, cout, zero}
  logic [W+1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic         rst;
    logic [2:0]   md;
    logic [W-1:0] dv;
    logic         sl;
    logic         sr;
    logic [W-1:0] eq;
    logic         ec;
    logic         ez;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [2:0] md, logic [W-1:0] dv,
                              logic sl, logic sr, logic [W-1:0] eq, logic ec, logic ez);
    vec_t v;
    v.rst = rst; v.md = md; v.dv = dv; v.sl = sl; v.sr = sr;
    v.eq = eq; v.ec = ec; v.ez = ez;
    return v;
  endfunction

  // driver: apply inputs for one edge, push expectation, compare after the edge
  task automatic step(input string name, input logic rst, input logic [2:0] md,
                      input logic [W-1:0] dv, input logic sl, input logic sr,
                      input logic [W+1:0] expv);
    logic [W+1:0] e;
    logic [W+1:0] got;
    @(negedge clk);
    reset = rst; mode = md; d = dv; sin_l = sl; sin_r = sr;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = {q, cout, zero};
    n_cmp++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got q=%h cout=%b zero=%b, want q=%h cout=%b zero=%b",
               name, got[W+1:2], got[1], got[0], e[W+1:2], e[1], e[0]);
    end
  endtask

  // reference model for the random phase
  logic [W-1:0] m_q;
  logic         m_c;

  task automatic model_step(input logic rst, input logic [2:0] md, input logic [W-1:0] dv,
                            input logic sl, input logic sr);
    logic [W-1:0] nq;
    logic         nc;
    nq = m_q; nc = m_c;
    if (rst) begin
      nq = '0; nc = 1'b0;
    end else begin
      case (md)
        3'd0: begin nq = m_q; nc = m_c; end
        3'd1: begin nq = dv; nc = 1'b0; end
        3'd2: begin nq = {m_q[W-2:0], sl}; nc = m_q[W-1]; end
        3'd3: begin nq = {sr, m_q[W-1:1]}; nc = m_q[0]; end
        3'd4: begin nq = {m_q[W-2:0], m_q[W-1]}; nc = m_q[W-1]; end
        3'd5: begin nq = {m_q[0], m_q[W-1:1]}; nc = m_q[0]; end
        3'd6: begin
          nc = (m_q == 8'hFF);
          nq = (SAT && nc) ? m_q : m_q + 8'd1;
        end
        default: begin
          nc = (m_q == 8'h00);
          nq = (SAT && nc) ? m_q : m_q - 8'd1;
        end
      endcase
    end
    m_q = nq; m_c = nc;
  endtask

  initial begin
    vec_t v;
    logic r, sl, sr;
    logic [2:0] md;
    logic [W-1:0] dv;

    reset = 1'b1; mode = MODE_HOLD; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    repeat (2) @(posedge clk);

    // plan 1: reset beats LOAD, load, hold
    vecs.push_back(mk(1, MODE_LOAD, 8'hA5, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, MODE_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 0));
    vecs.push_back(mk(0, MODE_HOLD, 8'h3C, 1, 1, 8'hA5, 0, 0));
    vecs.push_back(mk(0, MODE_HOLD, 8'h00, 0, 0, 8'hA5, 0, 0));
    vecs.push_back(mk(0, MODE_HOLD, 8'hFF, 1, 0, 8'hA5, 0, 0));
    // plan 2: shifts
    vecs.push_back(mk(0, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0, 0));
    vecs.push_back(mk(0, MODE_SHL,  8'hFF, 0, 0, 8'h02, 1, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'hFF, 0, 1, 8'h81, 0, 0));
    vecs.push_back(mk(0, MODE_SHL,  8'h00, 1, 0, 8'h03, 1, 0));
    vecs.push_back(mk(0, MODE_SHR,  8'h00, 1, 0, 8'h01, 1, 0));
    // plan 3: rotates, then HOLD keeps cout
    vecs.push_back(mk(0, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0, 0));
    vecs.push_back(mk(0, MODE_ROL,  8'h00, 0, 0, 8'h03, 1, 0));
    vecs.push_back(mk(0, MODE_ROR,  8'h00, 0, 0, 8'h81, 1, 0));
    vecs.push_back(mk(0, MODE_ROR,  8'h00, 0, 0, 8'hC0, 1, 0));
    vecs.push_back(mk(0, MODE_HOLD, 8'h00, 0, 0, 8'hC0, 1, 0));
    // plan 4: increment over the top
    vecs.push_back(mk(0, MODE_LOAD, 8'hFE, 0, 0, 8'hFE, 0, 0));
    vecs.push_back(mk(0, MODE_INC,  8'h00, 0, 0, 8'hFF, 0, 0));
    vecs.push_back(mk(0, MODE_INC,  8'h00, 0, 0, SAT ? 8'hFF : 8'h00, 1, SAT ? 1'b0 : 1'b1));
    vecs.push_back(mk(0, MODE_HOLD, 8'h00, 0, 0, SAT ? 8'hFF : 8'h00, 1, SAT ? 1'b0 : 1'b1));
    // plan 5: decrement under the bottom
    vecs.push_back(mk(0, MODE_LOAD, 8'h01, 0, 0, 8'h01, 0, 0));
    vecs.push_back(mk(0, MODE_DEC,  8'h00, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, MODE_DEC,  8'h00, 0, 0, SAT ? 8'h00 : 8'hFF, 1, SAT ? 1'b1 : 1'b0));
    // plan 6: reset aborts a count mid-sequence
    vecs.push_back(mk(0, MODE_LOAD, 8'h10, 0, 0, 8'h10, 0, 0));
    vecs.push_back(mk(0, MODE_INC,  8'h00, 0, 0, 8'h11, 0, 0));
    vecs.push_back(mk(0, MODE_INC,  8'h00, 0, 0, 8'h12, 0, 0));
    vecs.push_back(mk(1, MODE_INC,  8'h00, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, MODE_INC,  8'h00, 0, 0, 8'h01, 0, 0));
    vecs.push_back(mk(0, MODE_INC,  8'h00, 0, 0, 8'h02, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step($sformatf("vec%0d", i), v.rst, v.md, v.dv, v.sl, v.sr, {v.eq, v.ec, v.ez});
    end

    // hand sequence: reset with an unknown mode, after cout was set
    step("pre_x_load", 0, MODE_LOAD, 8'h80, 0, 0, {8'h80, 1'b0, 1'b0});
    step("pre_x_shl",  0, MODE_SHL,  8'h00, 0, 0, {8'h00, 1'b1, 1'b1});
    step("reset_xmode", 1, 3'bxxx,   8'h77, 1, 1, {8'h00, 1'b0, 1'b1});
    step("post_x_dec", 0, MODE_DEC,  8'h00, 0, 0,
         {SAT ? 8'h00 : 8'hFF, 1'b1, SAT ? 1'b1 : 1'b0});

    // random phase against the reference model
    m_q = '0; m_c = 1'b0;
    step("rand_reset", 1, MODE_HOLD, 8'h00, 0, 0, {8'h00, 1'b0, 1'b1});
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      md = 3'($urandom_range(0, 7));
      dv = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) dv = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      sl = 1'($urandom_range(0, 1));
      sr = 1'($urandom_range(0, 1));
      model_step(r, md, dv, sl, sr);
      step($sformatf("rand%0d", i), r, md, dv, sl, sr, {m_q, m_c, (m_q == 8'h00)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uni_reg.md
Name: uni_reg

Overview:
- Parametrised universal register. Successor to the single-bit load/reset flop, generalised to WIDTH bits.
- Eight operating modes: hold, load, shift left, shift right, rotate left, rotate right, increment, decrement.
- Registered carry/shift-out flag and a combinational zero flag.
- Used as the building block for address counters, shift chains and data latches in the RAM datapath.

Parameters:
WIDTH, 16, register width in bits (>=2)
RESET_VAL, 0, value loaded into q on reset (WIDTH bits)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
mode  input  3  operation select (encoding below)
d  input  WIDTH  parallel load value
sin_l  input  1  serial bit entering LSB on SHL
sin_r  input  1  serial bit entering MSB on SHR
q  output  WIDTH  register contents
cout  output  1  registered carry / borrow / shifted-out bit
zero  output  1  combinational, 1 when q == 0

Behaviour:
- Clocking: every state change occurs on the rising edge of clk. One-cycle latency from mode/d/sin_* to q and cout.
- Reset: synchronous and active-high, checked at the edge. Priority is reset > mode. On reset: q=RESET_VAL, cout=0, and zero reflects RESET_VAL. Asserting reset mid-sequence (during a count or shift) aborts that cycle's operation with no partial update.
- Mode encoding and next state (n = WIDTH):
  - 0 HOLD: q unchanged, cout unchanged.
  - 1 LOAD: q=d, cout=0.
  - 2 SHL: q={q[n-2:0],sin_l}, cout=q[n-1].
  - 3 SHR: q={sin_r,q[n-1:1]}, cout=q[0].
  - 4 ROL: q={q[n-2:0],q[n-1]}, cout=q[n-1].
  - 5 ROR: q={q[0],q[n-1:1]}, cout=q[0].
  - 6 INC: q=q+1 modulo 2^n; cout=1 iff q was all-ones, else 0.
  - 7 DEC: q=q-1 modulo 2^n; cout=1 iff q was 0 (borrow), else 0.
- cout is valid the cycle after the operation. HOLD preserves the last cout.
- zero is purely combinational from q. It has no extra latency and does not depend on mode.
- All 8 mode codes are defined; there are no illegal states.
- d, sin_l and sin_r are ignored in modes that do not use them.
- X on mode while reset=1 must not affect q.

Optional Feature:
- Macro: UNI_REG_SAT_EN.
- Defined: INC at all-ones holds q=all-ones with cout=1; DEC at 0 holds q=0 with cout=1. Non-boundary counts behave as normal.
- Undefined: INC/DEC wrap modulo 2^WIDTH as specified above.
- Shift, rotate, load, hold and reset are identical in both builds.

Decomposition:
- Package uni_reg_pkg holds:
  - mode width constant UNI_REG_MODE_W=3;
  - mode constants MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC.
- One sub-module, uni_reg_cell: a per-bit 8:1 next-state select (built from existing mux8) feeding a synchronous-reset flop with its per-bit reset value. Instantiated WIDTH times via generate.
- The inc/dec carry chain, cout logic and zero reduction live in the top level.

Test Plan (WIDTH=8, RESET_VAL=0):
1. reset=1 with mode=LOAD, d=8'hA5 for one edge -> q=8'h00, cout=0, zero=1. Then reset=0, LOAD 8'hA5 -> q=8'hA5, zero=0. Then HOLD for 3 edges -> q remains 8'hA5.
2. LOAD 8'h81, then SHL with sin_l=0 -> q=8'h02, cout=1. Then SHR with sin_r=1 -> q=8'h81, cout=0.
3. LOAD 8'h81, then ROL -> q=8'h03, cout=1. Then ROR -> q=8'h81, cout=1. Then ROR -> q=8'hC0, cout=1.
4. LOAD 8'hFE, then INC, INC:
   - without SAT: q=8'hFF cout=0, then q=8'h00 cout=1 zero=1;
   - with SAT: second INC gives q=8'hFF, cout=1.
5. LOAD 8'h01, then DEC, DEC:
   - without SAT: q=8'h00 zero=1 cout=0, then q=8'hFF cout=1;
   - with SAT: q stays 8'h00, cout=1.
6. INC for 5 cycles from 8'h10, with reset asserted on the 3rd edge -> q=8'h12 then 8'h00 at that edge, cout=0. Counting resumes from 0 after reset is deasserted.
